// File: rtl/ttt_pkg.sv
// -----------------------------------------------------------------------------
// ttt_pkg
// Types and constants shared between the TTT processor core and the token
// router: connectivity entry encoding, token start/stop event codes and the
// router FSM state encoding.
// -----------------------------------------------------------------------------
package ttt_pkg;

  typedef enum logic [1:0] {
    CONN_NONE = 2'b00,
    CONN_GOOD = 2'b01,
    CONN_BAD  = 2'b10
  } conn_kind_e;

  localparam logic [1:0] TOKEN_START = 2'b10;
  localparam logic [1:0] TOKEN_STOP  = 2'b01;

  typedef enum logic {
    ROUTER_IDLE,
    ROUTER_FANOUT
  } router_state_e;

endpackage

// File: rtl/tt_um_jleugeri_ttt_sat_accumulator.sv
// -----------------------------------------------------------------------------
// tt_um_jleugeri_ttt_sat_accumulator
// One signed saturating delta register.
//   clock_fast  in   clock, rising edge
//   reset_n     in   asynchronous active-low reset (value -> 0)
//   inc / dec   in   step the value by +1 / -1 (both together: no step)
//   clear       in   start from 0 this edge; a simultaneous step is applied
//                    on top of the cleared value so it is never lost
//   value       out  current signed value
//   clamp       out  combinational pulse: the requested step hit a limit
// -----------------------------------------------------------------------------
module tt_um_jleugeri_ttt_sat_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic                    clock_fast,
  input  logic                    reset_n,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clear,
  output logic signed [WIDTH-1:0] value,
  output logic                    clamp
);

  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);

  function automatic logic signed [WIDTH-1:0] sat_step(
    input logic signed [WIDTH-1:0] b,
    input logic                    up
  );
    if (up) return (b == MAX_VAL) ? b : b + ONE;
    else    return (b == MIN_VAL) ? b : b - ONE;
  endfunction

  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] value_next;

  always_comb begin
    base       = clear ? '0 : value;
    value_next = base;
    clamp      = 1'b0;
    if (inc && !dec) begin
      value_next = sat_step(base, 1'b1);
      clamp      = (base == MAX_VAL);
    end else if (dec && !inc) begin
      value_next = sat_step(base, 1'b0);
      clamp      = (base == MIN_VAL);
    end
  end

  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) value <= '0;
    else          value <= value_next;
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_token_router.sv
// -----------------------------------------------------------------------------
// tt_um_jleugeri_ttt_token_router
// Fans each token start/stop event from the processor core out over a
// programmable connectivity matrix, one target per cycle, and keeps signed
// saturating good/bad token deltas per target for the core to fetch & clear.
//   clock_fast, reset_n             clock / async active-low reset
//   event_valid/ready/source/startstop   token event handshake (ready == IDLE)
//   prog_enable/source/target/kind  write one connectivity entry
//   read_enable/read_target         present (and optionally clear) deltas
//   new_good_tokens/new_bad_tokens  deltas of read_target (combinational)
//   busy                            fan-out in progress
//   saturated                       sticky: some accumulator clamped
// -----------------------------------------------------------------------------
module tt_um_jleugeri_ttt_token_router
  import ttt_pkg::*;
#(
  parameter  int NEW_TOKENS_BITS = 4,
  parameter  int NUM_PROCESSORS  = 10,
  localparam int PID_BITS        = $clog2(NUM_PROCESSORS)
) (
  input  logic                              clock_fast,
  input  logic                              reset_n,
  input  logic                              event_valid,
  output logic                              event_ready,
  input  logic [PID_BITS-1:0]               event_source,
  input  logic [1:0]                        event_startstop,
  input  logic                              prog_enable,
  input  logic [PID_BITS-1:0]               prog_source,
  input  logic [PID_BITS-1:0]               prog_target,
  input  logic [1:0]                        prog_kind,
  input  logic                              read_enable,
  input  logic [PID_BITS-1:0]               read_target,
  output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                              busy,
  output logic                              saturated
);

  localparam logic [PID_BITS:0]   NUM_P    = (PID_BITS+1)'(NUM_PROCESSORS);
  localparam logic [PID_BITS-1:0] LAST_TGT = PID_BITS'(NUM_PROCESSORS - 1);

  function automatic logic in_range(input logic [PID_BITS-1:0] id);
    return {1'b0, id} < NUM_P;
  endfunction

  router_state_e       state_q, state_next;
  logic [PID_BITS-1:0] src_q, tgt_q;
  logic                neg_q;
  logic                start_fanout;
  conn_kind_e          conn [NUM_PROCESSORS][NUM_PROCESSORS];
  conn_kind_e          cur_kind;
  conn_kind_e          prog_kind_dec;

  logic signed [NEW_TOKENS_BITS-1:0] good_val [NUM_PROCESSORS];
  logic signed [NEW_TOKENS_BITS-1:0] bad_val  [NUM_PROCESSORS];
  logic [NUM_PROCESSORS-1:0]         clamp_good, clamp_bad;

  // FSM next state; no-op codes and out-of-range sources are accepted in IDLE
  // but never start a fan-out.
  always_comb begin
    state_next   = state_q;
    start_fanout = 1'b0;
    case (state_q)
      ROUTER_IDLE: begin
        if (event_valid && in_range(event_source) &&
            (event_startstop == TOKEN_START || event_startstop == TOKEN_STOP)) begin
          start_fanout = 1'b1;
          state_next   = ROUTER_FANOUT;
        end
      end
      ROUTER_FANOUT: begin
        if (tgt_q == LAST_TGT) state_next = ROUTER_IDLE;
      end
      default: state_next = ROUTER_IDLE;
    endcase
  end

  assign event_ready = (state_q == ROUTER_IDLE);
  assign busy        = !event_ready;

  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ROUTER_IDLE;
      src_q   <= '0;
      tgt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      if (start_fanout) begin
        src_q <= event_source;
        neg_q <= (event_startstop == TOKEN_STOP);
        tgt_q <= '0;
      end else if (state_q == ROUTER_FANOUT && tgt_q != LAST_TGT) begin
        tgt_q <= tgt_q + PID_BITS'(1);
      end
    end
  end

  // Code 2'b11 is stored as NONE so the matrix only ever holds enum values.
  always_comb begin
    case (prog_kind)
      2'b01:   prog_kind_dec = CONN_GOOD;
      2'b10:   prog_kind_dec = CONN_BAD;
      default: prog_kind_dec = CONN_NONE;
    endcase
  end

  // Nonblocking write: a fan-out reading the same entry this cycle sees the
  // old value.
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PROCESSORS; i++)
        for (int j = 0; j < NUM_PROCESSORS; j++)
          conn[i][j] <= CONN_NONE;
    end else if (prog_enable && in_range(prog_source) && in_range(prog_target)) begin
      conn[prog_source][prog_target] <= prog_kind_dec;
    end
  end

  assign cur_kind = conn[src_q][tgt_q];

  for (genvar t = 0; t < NUM_PROCESSORS; t++) begin : g_acc
    logic hit, clr;
    assign hit = (state_q == ROUTER_FANOUT) && (tgt_q == PID_BITS'(t));
    assign clr = read_enable && in_range(read_target) && (read_target == PID_BITS'(t));

    tt_um_jleugeri_ttt_sat_accumulator #(.WIDTH(NEW_TOKENS_BITS)) u_good (
      .clock_fast (clock_fast),
      .reset_n    (reset_n),
      .inc        (hit && cur_kind == CONN_GOOD && !neg_q),
      .dec        (hit && cur_kind == CONN_GOOD &&  neg_q),
      .clear      (clr),
      .value      (good_val[t]),
      .clamp      (clamp_good[t])
    );

    tt_um_jleugeri_ttt_sat_accumulator #(.WIDTH(NEW_TOKENS_BITS)) u_bad (
      .clock_fast (clock_fast),
      .reset_n    (reset_n),
      .inc        (hit && cur_kind == CONN_BAD && !neg_q),
      .dec        (hit && cur_kind == CONN_BAD &&  neg_q),
      .clear      (clr),
      .value      (bad_val[t]),
      .clamp      (clamp_bad[t])
    );
  end

  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n)                     saturated <= 1'b0;
    else if (|{clamp_good, clamp_bad}) saturated <= 1'b1;
  end

  always_comb begin
    new_good_tokens = '0;
    new_bad_tokens  = '0;
    if (in_range(read_target)) begin
      new_good_tokens = good_val[read_target];
      new_bad_tokens  = bad_val[read_target];
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_router.sv
module tb_tt_um_jleugeri_ttt_token_router;

  localparam int NT = 4;
  localparam int NP = 10;
  localparam int PB = $clog2(NP);
  localparam int HI = (1 << (NT - 1)) - 1;
  localparam int LO = -(1 << (NT - 1));

  logic                 clock_fast = 1'b0;
  logic                 reset_n;
  logic                 event_valid, event_ready;
  logic [PB-1:0]        event_source;
  logic [1:0]           event_startstop;
  logic                 prog_enable;
  logic [PB-1:0]        prog_source, prog_target;
  logic [1:0]           prog_kind;
  logic                 read_enable;
  logic [PB-1:0]        read_target;
  logic signed [NT-1:0] new_good_tokens, new_bad_tokens;
  logic                 busy, saturated;

  tt_um_jleugeri_ttt_token_router #(.NEW_TOKENS_BITS(NT), .NUM_PROCESSORS(NP)) dut (
    .clock_fast      (clock_fast),
    .reset_n         (reset_n),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_source    (event_source),
    .event_startstop (event_startstop),
    .prog_enable     (prog_enable),
    .prog_source     (prog_source),
    .prog_target     (prog_target),
    .prog_kind       (prog_kind),
    .read_enable     (read_enable),
    .read_target     (read_target),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .busy            (busy),
    .saturated       (saturated)
  );

  always #5 clock_fast = ~clock_fast;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole fan-out applied at once ----------
  int good_m [NP];
  int bad_m  [NP];
  int conn_m [NP][NP];   // 0 none, 1 good, 2 bad
  bit sat_m;

  typedef struct { int tgt; int g; int b; } exp_t;
  exp_t sb [$];

  function automatic void model_reset();
    sat_m = 0;
    for (int i = 0; i < NP; i++) begin
      good_m[i] = 0; bad_m[i] = 0;
      for (int j = 0; j < NP; j++) conn_m[i][j] = 0;
    end
  endfunction

  function automatic int clampv(input int v);
    if (v > HI) begin sat_m = 1; return HI; end
    if (v < LO) begin sat_m = 1; return LO; end
    return v;
  endfunction

  function automatic void model_prog(input int s, input int t, input int k);
    if (s < NP && t < NP) conn_m[s][t] = (k == 1 || k == 2) ? k : 0;
  endfunction

  function automatic void model_event(input int s, input int code);
    int sign;
    if (s >= NP || !(code == 2 || code == 1)) return;
    sign = (code == 2) ? 1 : -1;
    for (int t = 0; t < NP; t++) begin
      if (conn_m[s][t] == 1) good_m[t] = clampv(good_m[t] + sign);
      if (conn_m[s][t] == 2) bad_m[t]  = clampv(bad_m[t] + sign);
    end
  endfunction

  function automatic void model_read(input int t);
    exp_t e;
    e.tgt = t;
    e.g   = (t < NP) ? good_m[t] : 0;
    e.b   = (t < NP) ? bad_m[t]  : 0;
    sb.push_back(e);
    if (t < NP) begin good_m[t] = 0; bad_m[t] = 0; end
  endfunction

  // ---------------- monitor: pops an expectation on every read strobe -------
  always @(negedge clock_fast) begin
    if (reset_n) begin
      check("ready_is_not_busy", int'(event_ready), int'(!busy));
      if (read_enable) begin
        if (sb.size() == 0) begin
          check("scoreboard_has_entry", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("read_target", int'(read_target), e.tgt);
          check("read_good", int'(new_good_tokens), e.g);
          check("read_bad", int'(new_bad_tokens), e.b);
        end
      end
    end
  end

  // ---------------- driver tasks --------------------------------------------
  task automatic tick();
    @(posedge clock_fast); #1;
  endtask

  task automatic do_prog(input int s, input int t, input int k);
    prog_source = s[PB-1:0]; prog_target = t[PB-1:0]; prog_kind = k[1:0];
    prog_enable = 1'b1;
    tick();
    prog_enable = 1'b0;
    model_prog(s, t, k);
  endtask

  // Offers an event and returns right after the accepting edge (+1).
  task automatic send_event(input int s, input int code, output int waited);
    bit ok = 0;
    waited = 0;
    event_source = s[PB-1:0]; event_startstop = code[1:0]; event_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock_fast);
      ok = event_ready;
      if (!ok) waited++;
      @(posedge clock_fast); #1;
    end
    event_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int busy_cycles);
    bit done = 0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock_fast);
      if (!busy) done = 1; else busy_cycles++;
      @(posedge clock_fast); #1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic event_full(input int s, input int code);
    int w, b;
    send_event(s, code, w);
    model_event(s, code);
    wait_idle(b);
  endtask

  task automatic do_read(input int t, input bit en);
    read_target = t[PB-1:0];
    read_enable = en;
    if (en) model_read(t);
    tick();
    read_enable = 1'b0;
  endtask

  task automatic peek(input int t);
    read_target = t[PB-1:0];
    read_enable = 1'b0;
    #1;
    check("peek_good", int'(new_good_tokens), (t < NP) ? good_m[t] : 0);
    check("peek_bad", int'(new_bad_tokens), (t < NP) ? bad_m[t] : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bc;
    reset_n = 1'b0; event_valid = 0; event_source = '0; event_startstop = '0;
    prog_enable = 0; prog_source = '0; prog_target = '0; prog_kind = '0;
    read_enable = 0; read_target = '0;
    model_reset();
    repeat (3) tick();
    check("reset_ready", int'(event_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_sat", int'(saturated), 0);
    peek(0);
    reset_n = 1'b1;
    tick();

    // single start from source 2, conn[2][5] = good
    do_prog(2, 5, 1);
    send_event(2, 2, w);
    model_event(2, 2);
    wait_idle(bc);
    check("fanout_busy_cycles", bc, NP);
    for (int t = 0; t < NP; t++) do_read(t, 1);

    // start then stop with conn[2][5] = bad; the stop is offered while busy
    do_prog(2, 5, 2);
    send_event(2, 2, w);
    model_event(2, 2);
    send_event(2, 1, w);
    check("held_event_wait", w, NP);
    model_event(2, 1);
    wait_idle(bc);
    do_read(5, 1);

    // saturation on good_acc[3]
    check("sat_before", int'(saturated), 0);
    do_prog(0, 3, 1);
    repeat (8) event_full(0, 2);
    peek(3);
    check("sat_high", int'(saturated), int'(sat_m));
    check("sat_high_is_set", int'(saturated), 1);
    repeat (16) event_full(0, 1);
    peek(3);
    check("sat_low_value", int'(new_good_tokens), LO);

    // read/fan-out collision on target 4
    do_prog(1, 4, 1);
    event_full(1, 2);
    event_full(1, 2);
    send_event(1, 2, w);
    repeat (4) tick();
    read_target = PB'(4); read_enable = 1'b1;
    model_read(4);
    model_event(1, 2);
    tick();
    read_enable = 1'b0;
    peek(4);
    check("collision_value", int'(new_good_tokens), 1);
    wait_idle(bc);

    // no-op code and out-of-range source
    send_event(3, 3, w);
    @(negedge clock_fast);
    check("noop_busy", int'(busy), 0);
    @(posedge clock_fast); #1;
    send_event(12, 2, w);
    @(negedge clock_fast);
    check("oor_src_busy", int'(busy), 0);
    @(posedge clock_fast); #1;
    for (int t = 0; t < NP; t++) peek(t);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2)      do_prog($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3));
      else if (op <= 5) event_full($urandom_range(0, 11), $urandom_range(0, 3));
      else if (op <= 8) do_read($urandom_range(0, 11), 1'($urandom_range(0, 1)));
      else begin
        peek($urandom_range(0, 11));
        check("rand_sat", int'(saturated), int'(sat_m));
      end
    end

    // reset in the middle of a fan-out
    do_prog(6, 7, 1);
    send_event(6, 2, w);
    repeat (3) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_ready", int'(event_ready), 1);
    check("midreset_sat", int'(saturated), 0);
    peek(7);
    tick();
    reset_n = 1'b1;
    tick();
    event_full(6, 2);
    for (int t = 0; t < NP; t++) do_read(t, 1);

    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
